io_peripheral: RTL and testbench
================================

Name: io_peripheral

Overview:
- CPU-side I/O responder. It drives the CPU's `input_port` and `interrupt` inputs, and it captures the CPU's `OUT` byte.
- External bytes are buffered in a small input FIFO. The head byte is presented on `input_port`, and a fixed-length interrupt pulse is raised for each byte until the CPU consumes it.
- CPU output writes are held in a one-entry register and drained downstream over a valid/ready handshake.
- Sits beside CPU at top level; replaces bench-driven `intr`/`input_port`.

Parameters:
- `DEPTH`, 4, input FIFO entries (power of 2, ≥2)
- `INTR_CYCLES`, 3, cycles `interrupt` is held high per request (≥1)
- `DATA_W`, 8, byte width of all data paths

Ports:
- `clk` input 1 system clock, rising edge
- `reset` input 1 asynchronous, active-high reset
- `ext_data` input `DATA_W` byte from external source
- `ext_valid` input 1 `ext_data` valid
- `ext_ready` output 1 FIFO can accept a byte (count < `DEPTH`)
- `in_rd` input 1 CPU executed IN; consume head byte this cycle
- `input_port` output `DATA_W` FIFO head byte to CPU; 0 when empty
- `interrupt` output 1 interrupt request to CPU
- `out_wr` input 1 CPU executed OUT; `cpu_out` valid this cycle
- `cpu_out` input `DATA_W` CPU `OUT` byte
- `out_data` output `DATA_W` held output byte
- `out_valid` output 1 `out_data` holds an undelivered byte
- `out_ready` input 1 downstream accepts `out_data`
- `out_ovf` output 1 sticky: an `out_wr` byte was dropped
- `fifo_count` output clog2(`DEPTH`)+1 current FIFO occupancy

Behaviour:
- Reset (async, immediate) clears all state. FIFO is empty and `fifo_count`=0. FSM goes to IDLE. Outputs: `interrupt`=0, `out_valid`=0, `out_data`=0, `out_ovf`=0, `ext_ready`=1, `input_port`=0.
- Reset mid-operation discards all buffered bytes and any pending interrupt.
- **Input FIFO push/pop**
  - Push on `ext_valid` && `ext_ready` at the rising edge.
  - Pop on `in_rd` && count≠0. `in_rd` while empty is ignored and has no side effect.
  - Push and pop in the same cycle: count unchanged, head advances, new byte written at tail.
  - When full, `ext_ready`=0, so no push occurs; an `in_rd` that cycle still pops. `ext_ready` is combinational from count.
  - Pointers wrap modulo `DEPTH`.
- **input_port**
  - Combinational from registered storage: `input_port` = mem[head] when count≠0, else 0.
  - Updates the cycle after a pop.
- **Interrupt FSM** (registered `interrupt`)
  - IDLE: `interrupt`=0. If count≠0, go to PULSE at the next edge, load pulse counter with `INTR_CYCLES`-1, clear ack flag.
  - PULSE: `interrupt`=1.
    - Counter decrements each cycle.
    - An `in_rd` pop during PULSE sets the ack flag; it does not shorten the pulse.
    - When the counter reaches 0, go to IDLE if the ack flag is set (or `in_rd` this cycle), else go to WAIT.
  - WAIT: `interrupt`=0. A pop (`in_rd` with count≠0) goes to IDLE.
  - Re-entry: IDLE re-evaluates count. If bytes remain, a new pulse starts one cycle after entering IDLE, so there is ≥1 low cycle between pulses.
  - Latency: a byte pushed at edge k into an empty FIFO gives `interrupt` high for cycles k+1 through k+`INTR_CYCLES` (sampled after edges k+1 … k+`INTR_CYCLES`).
- **Output register**
  - Slot is free if `out_valid`=0, or if `out_valid`&&`out_ready` this cycle (drain and refill in the same cycle).
  - `out_wr` with slot free: `out_data`←`cpu_out`, `out_valid`←1.
  - `out_wr` with slot occupied and not draining: byte dropped, `out_data` unchanged, `out_ovf`←1. `out_ovf` is cleared only by reset.
  - `out_valid`&&`out_ready` with no `out_wr`: `out_valid`←0 and `out_data` holds its last value.
  - Latency: `out_wr` at edge k gives `out_valid`=1 after edge k.

Test Plan:
- Reset check: assert `reset` asynchronously mid-cycle while FIFO holds 2 bytes and `interrupt`=1 → all outputs go to reset values immediately, and no interrupt follows after release.
- Single byte: push 0xA5 at edge 5 → `input_port`=0xA5 after edge 5; `interrupt`=1 after edges 6, 7, 8 and 0 after edge 9 (FSM in WAIT). `in_rd` at edge 12 → `input_port`=0, `fifo_count`=0, and no further pulse.
- Fill/back-pressure: push 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles with `DEPTH`=4 → `ext_ready`=0 after the fourth push and 0x55 is held off. Four `in_rd` pops yield 0x11–0x44 in order, and 0x55 enters once `ext_ready`=1.
- Ack during pulse plus re-arm: FIFO holds 0x01, 0x02; `in_rd` in 2nd pulse cycle → pulse still 3 cycles, then IDLE 1 cycle low, then a new 3-cycle pulse with `input_port`=0x02.
- Simultaneous push and pop at count=2 → `fifo_count` stays 2 and order is preserved across pointer wrap (run 10 such cycles).
- Output path: `out_wr` 0x3C with `out_ready`=0, then `out_wr` 0x7E → `out_data`=0x3C and `out_ovf`=1. Next, `out_ready`=1 together with `out_wr` 0x99 → `out_data`=0x99 with `out_valid` remaining 1.

Source files
------------

// File: rtl/io_peripheral.sv
// io_peripheral: CPU-side I/O responder.
//   Buffers external bytes in a DEPTH-entry FIFO whose head byte is shown
//   to the CPU on input_port, raises a fixed-length interrupt pulse while
//   bytes are waiting, and holds CPU OUT bytes in a one-entry register that
//   drains downstream over a valid/ready handshake.
// Ports:
//   clk, reset              - clock (rising edge), async active-high reset
//   ext_data/ext_valid      - external byte source; ext_ready = FIFO not full
//   in_rd                   - CPU executed IN, consumes the head byte
//   input_port              - FIFO head byte (0 when empty)
//   interrupt               - registered interrupt request to the CPU
//   out_wr/cpu_out          - CPU executed OUT with this byte
//   out_data/out_valid      - held output byte towards downstream
//   out_ready               - downstream accepts out_data
//   out_ovf                 - sticky: an OUT byte was dropped
//   fifo_count              - current FIFO occupancy
module io_peripheral #(
    parameter int DEPTH       = 4,
    parameter int INTR_CYCLES = 3,
    parameter int DATA_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        ext_data,
    input  logic                     ext_valid,
    output logic                     ext_ready,
    input  logic                     in_rd,
    output logic [DATA_W-1:0]        input_port,
    output logic                     interrupt,
    input  logic                     out_wr,
    input  logic [DATA_W-1:0]        cpu_out,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_ovf,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int CNTW = (INTR_CYCLES > 1) ? $clog2(INTR_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_s, pop_s, fifo_nonempty_s;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic              interrupt_q;

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_ovf_q, out_ovf_d;
    logic              slot_free_s;

    assign fifo_nonempty_s = (count_q != {CW{1'b0}});
    assign ext_ready       = (count_q != CW'(DEPTH));
    assign push_s          = ext_valid && ext_ready;
    // An IN while empty is ignored entirely, including by the FSM.
    assign pop_s           = in_rd && fifo_nonempty_s;
    assign input_port      = fifo_nonempty_s ? mem_q[head_q] : {DATA_W{1'b0}};
    assign fifo_count      = count_q;
    assign interrupt       = interrupt_q;
    assign out_data        = out_data_q;
    assign out_valid       = out_valid_q;
    assign out_ovf         = out_ovf_q;

    // FIFO pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_s) begin
            tail_d = tail_q + AW'(1);
        end else begin
            tail_d = tail_q;
        end
        if (pop_s) begin
            head_d = head_q + AW'(1);
        end else begin
            head_d = head_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage and pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            head_q  <= {AW{1'b0}};
            tail_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_q[tail_q] <= ext_data;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Interrupt FSM next-state: the pulse always runs its full length, and
    // an acknowledge seen during it decides between IDLE and WAIT at the end.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = ack_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_nonempty_s) begin
                    state_d = ST_PULSE;
                    cnt_d   = CNTW'(INTR_CYCLES - 1);
                    ack_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (pop_s) begin
                    ack_d = 1'b1;
                end else begin
                    ack_d = ack_q;
                end
                if (cnt_q == {CNTW{1'b0}}) begin
                    if (ack_q || pop_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            ST_WAIT: begin
                if (pop_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Interrupt FSM registers; interrupt is registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNTW{1'b0}};
            ack_q       <= 1'b0;
            interrupt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            interrupt_q <= (state_d == ST_PULSE);
        end
    end

    // Output slot next-state: a draining slot may be refilled in the same cycle.
    assign slot_free_s = !out_valid_q || out_ready;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_ovf_d   = out_ovf_q;
        if (out_wr && slot_free_s) begin
            out_data_d  = cpu_out;
            out_valid_d = 1'b1;
        end else if (out_wr) begin
            out_ovf_d   = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output slot registers; out_ovf is sticky until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q  <= {DATA_W{1'b0}};
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_io_peripheral.sv
// Self-checking bench for io_peripheral: FIFO bytes and drained output
// bytes are tracked in scoreboard queues; interrupt timing is checked
// against fixed per-cycle expectations.
module tb_io_peripheral;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] ext_data;
    logic              ext_valid;
    logic              ext_ready;
    logic              in_rd;
    logic [DATA_W-1:0] input_port;
    logic              interrupt;
    logic              out_wr;
    logic [DATA_W-1:0] cpu_out;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_ovf;
    logic [2:0]        fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] fifo_sb [$];
    logic [DATA_W-1:0] out_sb  [$];

    io_peripheral #(.DEPTH(DEPTH), .INTR_CYCLES(3), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .ext_data   (ext_data),
        .ext_valid  (ext_valid),
        .ext_ready  (ext_ready),
        .in_rd      (in_rd),
        .input_port (input_port),
        .interrupt  (interrupt),
        .out_wr     (out_wr),
        .cpu_out    (cpu_out),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ovf    (out_ovf),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_intr"},  interrupt,  0);
        check({tag, "_oval"},  out_valid,  0);
        check({tag, "_odat"},  out_data,   0);
        check({tag, "_ovf"},   out_ovf,    0);
        check({tag, "_rdy"},   ext_ready,  1);
        check({tag, "_inp"},   input_port, 0);
        check({tag, "_cnt"},   fifo_count, 0);
    endtask

    // One clock cycle with scoreboard bookkeeping for the currently driven inputs.
    task automatic step();
        logic rdy;
        rdy = (fifo_sb.size() < DEPTH);
        check("ext_ready", ext_ready, rdy);
        if (in_rd && fifo_sb.size() != 0) begin
            check("pop_data", input_port, fifo_sb.pop_front());
        end
        if (ext_valid && rdy) begin
            fifo_sb.push_back(ext_data);
        end
        if (out_valid && out_ready) begin
            if (out_sb.size() == 0) begin
                check("drain_unexp", out_valid, 0);
            end else begin
                check("drain_data", out_data, out_sb.pop_front());
            end
        end
        @(posedge clk);
        #1;
        check("fifo_count", fifo_count, fifo_sb.size());
        check("input_port", input_port, (fifo_sb.size() != 0) ? fifo_sb[0] : 8'h00);
    endtask

    task automatic clear_inputs();
        ext_data  = 8'h00;
        ext_valid = 1'b0;
        in_rd     = 1'b0;
        out_wr    = 1'b0;
        cpu_out   = 8'h00;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        fifo_sb.delete();
        out_sb.delete();
        @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #1;
        check_reset_vals("por");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single byte: pulse of 3 cycles, then WAIT until consumed.
        ext_data = 8'hA5; ext_valid = 1'b1;
        step();
        ext_valid = 1'b0;
        check("sb_intr_k", interrupt, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("sb_intr_pulse", interrupt, 1);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            check("sb_intr_wait", interrupt, 0);
        end
        in_rd = 1'b1;
        step();
        in_rd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("sb_intr_after", interrupt, 0);
        end

        // Fill and back-pressure.
        do_reset();
        ext_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            ext_data = 8'(i * 8'h11);
            step();
        end
        check("fill_full_rdy", ext_ready, 0);
        in_rd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic acc;
            acc = ext_valid && (fifo_sb.size() < DEPTH);
            step();
            if (acc) ext_valid = 1'b0;
        end
        in_rd = 1'b0;
        check("fill_empty", fifo_sb.size(), 0);
        check("fill_55_used", ext_valid, 0);

        // Acknowledge during the pulse, then re-arm for the next byte.
        do_reset();
        ext_valid = 1'b1; ext_data = 8'h01;
        step();
        ext_data = 8'h02;
        step();
        ext_valid = 1'b0;
        check("ack_p1", interrupt, 1);
        step();
        check("ack_p2", interrupt, 1);
        in_rd = 1'b1;
        step();
        in_rd = 1'b0;
        check("ack_p3", interrupt, 1);
        step();
        check("ack_gap", interrupt, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ack_rearm", interrupt, 1);
            check("ack_inp", input_port, 8'h02);
        end
        step();
        check("ack_wait", interrupt, 0);

        // Simultaneous push and pop across pointer wrap.
        do_reset();
        ext_valid = 1'b1;
        ext_data = 8'hC0; step();
        ext_data = 8'hC1; step();
        in_rd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ext_data = 8'($urandom_range(0, 255));
            step();
            check("simul_cnt", fifo_count, 2);
        end
        clear_inputs();

        // Output path: overflow, then drain-and-refill, then plain drain.
        do_reset();
        out_wr = 1'b1; cpu_out = 8'h3C;
        step();
        out_sb.push_back(8'h3C);
        check("out_v1", out_valid, 1);
        check("out_d1", out_data, 8'h3C);
        check("out_ovf0", out_ovf, 0);
        cpu_out = 8'h7E;
        step();
        check("out_d2", out_data, 8'h3C);
        check("out_ovf1", out_ovf, 1);
        out_ready = 1'b1; cpu_out = 8'h99;
        step();
        out_sb.push_back(8'h99);
        check("out_d3", out_data, 8'h99);
        check("out_v3", out_valid, 1);
        out_wr = 1'b0;
        step();
        check("out_v4", out_valid, 0);
        check("out_d4", out_data, 8'h99);
        check("out_ovf_sticky", out_ovf, 1);
        check("out_sb_empty", out_sb.size(), 0);

        // Mid-operation async reset with 2 bytes buffered and interrupt high.
        out_ready = 1'b0; out_wr = 1'b1; cpu_out = 8'h5A;
        ext_valid = 1'b1; ext_data = 8'hE1;
        step();
        out_wr = 1'b0;
        ext_data = 8'hE2;
        step();
        ext_valid = 1'b0;
        check("mid_intr", interrupt, 1);
        check("mid_cnt", fifo_count, 2);
        check("mid_oval", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("mid");
        fifo_sb.delete();
        out_sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_intr", interrupt, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
